// File: rtl/cam_dma_gearbox_pkg.sv
// cam_dma_pkg: shared widths and encodings for the camera DMA gearbox
package cam_dma_pkg;
  localparam int IN_W = 48;
  localparam int OUT_W = 32;
  localparam int CNT_W = 24;
  typedef enum logic [1:0] {P0, P1, P2} phase_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/cam_dma_gearbox_core.sv
// cam_dma_gearbox_core: 48->32 phase/residue packer with a valid/ready output register
module cam_dma_gearbox_core
  import cam_dma_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             last,
  input  logic             clr,
  input  logic [IN_W-1:0]  fifo_rdata,
  input  logic             fifo_empty,
  input  logic             tready,
  output logic             fifo_rd_en,
  output logic             load,
  output logic             holding,
  output logic [OUT_W-1:0] tdata,
  output logic             tvalid,
  output logic             tlast
);
  phase_t phase;
  logic [OUT_W-1:0] residue, word, residue_nxt;
  always_comb begin
    load = run && (!tvalid || tready) && (phase == P2 || !fifo_empty);
    fifo_rd_en = load && phase != P2;
    holding = phase != P0;
    word = phase == P0 ? fifo_rdata[31:0] : phase == P1 ? {fifo_rdata[15:0], residue[15:0]} : residue;
    residue_nxt = phase == P0 ? {16'h0, fifo_rdata[47:32]} : phase == P1 ? fifo_rdata[47:16] : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      phase <= P0;
      residue <= '0;
      tdata <= '0;
      tvalid <= 1'b0;
      tlast <= 1'b0;
    end else begin
      if (clr) begin
        phase <= P0;
        residue <= '0;
      end else if (load) begin
        phase <= phase == P0 ? P1 : phase == P1 ? P2 : P0;
        residue <= residue_nxt;
      end
      if (load) begin
        tdata <= word;
        tvalid <= 1'b1;
        tlast <= last;
      end else if (tready) begin
        tvalid <= 1'b0;
        tlast <= 1'b0;
      end
    end
endmodule

// File: rtl/cam_dma_gearbox.sv
// cam_dma_gearbox: frame-oriented repacker from the 48-bit camera FIFO to a 32-bit stream
module cam_dma_gearbox
  import cam_dma_pkg::*;
(
  input  logic             clk_i,
  input  logic             a_rstn_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] frame_words_i,
  input  logic [IN_W-1:0]  fifo_rdata_i,
  input  logic             fifo_empty_i,
  output logic             fifo_rd_en_o,
  output logic [OUT_W-1:0] m_tdata_o,
  output logic             m_tvalid_o,
  output logic             m_tlast_o,
  input  logic             m_tready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             resid_drop_o
);
  state_t state, state_nxt;
  logic [CNT_W-1:0] words_left;
  logic load, holding, accept, arm, clr;
  always_comb begin
    accept = m_tvalid_o && m_tready_i;
    arm = state == IDLE && start_i;
    clr = state == DRAIN && accept;
    busy_o = state != IDLE;
    state_nxt = state;
    case (state)
      IDLE:    if (start_i && frame_words_i != '0) state_nxt = RUN;
      RUN:     if (load && words_left == CNT_W'(1)) state_nxt = DRAIN;
      DRAIN:   if (accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge a_rstn_i)
    if (!a_rstn_i) begin
      state <= IDLE;
      words_left <= '0;
      done_o <= 1'b0;
      resid_drop_o <= 1'b0;
    end else begin
      state <= state_nxt;
      if (arm && frame_words_i != '0) words_left <= frame_words_i;
      else if (load) words_left <= words_left - CNT_W'(1);
      done_o <= (arm && frame_words_i == '0) || clr;
      resid_drop_o <= clr && holding;
    end
  cam_dma_gearbox_core u_core (
    .clk        (clk_i),
    .rst_n      (a_rstn_i),
    .run        (state == RUN),
    .last       (words_left == CNT_W'(1)),
    .clr        (clr),
    .fifo_rdata (fifo_rdata_i),
    .fifo_empty (fifo_empty_i),
    .tready     (m_tready_i),
    .fifo_rd_en (fifo_rd_en_o),
    .load       (load),
    .holding    (holding),
    .tdata      (m_tdata_o),
    .tvalid     (m_tvalid_o),
    .tlast      (m_tlast_o)
  );
endmodule

// File: tb/tb_cam_dma_gearbox.sv
// tb_cam_dma_gearbox: directed bench with an FWFT FIFO model and a negedge stream monitor
module tb_cam_dma_gearbox;
  import cam_dma_pkg::*;
  logic clk_i = 1'b0;
  logic a_rstn_i, start_i, m_tready_i;
  logic [CNT_W-1:0] frame_words_i;
  logic [47:0] fifo_rdata_i;
  logic fifo_empty_i, fifo_rd_en_o, m_tvalid_o, m_tlast_o, busy_o, done_o, resid_drop_o;
  logic [31:0] m_tdata_o;
  logic [47:0] mem [32];
  logic [4:0] wptr, rptr;
  int cyc = 0, nb = 0, npop = 0, ndone = 0, done_cyc = 0, stall_chk = 0, stall_bad = 0;
  logic last_drop = 1'b0, pop_q = 1'b0, prev_stall = 1'b0;
  logic [32:0] prev_beat = '0;
  logic [32:0] beat [64];
  int beat_cyc [64];
  int checks = 0, errors = 0;

  cam_dma_gearbox dut (
    .clk_i(clk_i), .a_rstn_i(a_rstn_i), .start_i(start_i), .frame_words_i(frame_words_i),
    .fifo_rdata_i(fifo_rdata_i), .fifo_empty_i(fifo_empty_i), .fifo_rd_en_o(fifo_rd_en_o),
    .m_tdata_o(m_tdata_o), .m_tvalid_o(m_tvalid_o), .m_tlast_o(m_tlast_o), .m_tready_i(m_tready_i),
    .busy_o(busy_o), .done_o(done_o), .resid_drop_o(resid_drop_o)
  );

  always #5 clk_i = ~clk_i;

  // FWFT FIFO model; it shares the DUT reset, which empties it
  assign fifo_empty_i = rptr == wptr;
  assign fifo_rdata_i = mem[rptr];
  always @(posedge clk_i or negedge a_rstn_i)
    if (!a_rstn_i) rptr <= wptr;
    else if (pop_q) rptr <= rptr + 5'd1;

  always @(negedge clk_i) begin
    cyc <= cyc + 1;
    pop_q <= fifo_rd_en_o;
    if (fifo_rd_en_o) npop <= npop + 1;
    if (m_tvalid_o && m_tready_i) begin
      beat[nb] <= {m_tlast_o, m_tdata_o};
      beat_cyc[nb] <= cyc + 1;
      nb <= nb + 1;
    end
    if (done_o) begin
      ndone <= ndone + 1;
      done_cyc <= cyc + 1;
      last_drop <= resid_drop_o;
    end
    if (prev_stall) stall_chk <= stall_chk + 1;
    stall_bad <= stall_bad + ((prev_stall && prev_beat != {m_tlast_o, m_tdata_o}) ? 1 : 0)
                           + ((m_tvalid_o && !m_tready_i && fifo_rd_en_o) ? 1 : 0);
    prev_stall <= m_tvalid_o && !m_tready_i;
    prev_beat <= {m_tlast_o, m_tdata_o};
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [47:0] w);
    mem[wptr] = w;
    wptr = wptr + 5'd1;
  endtask

  task automatic start_frame(input logic [CNT_W-1:0] n);
    start_i = 1'b1;
    frame_words_i = n;
    step();
    start_i = 1'b0;
  endtask

  task automatic wait_nb(input int target, input string tag);
    int k = 0;
    while (nb < target && k < 200) begin
      step();
      k++;
    end
    chk(tag, nb >= target, 1);
  endtask

  task automatic wait_done(input int target, input string tag);
    int k = 0;
    while (ndone < target && k < 200) begin
      step();
      k++;
    end
    chk(tag, ndone >= target, 1);
  endtask

  initial begin
    int b0, p0, d0, s0, sb0, cp;
    logic [5:0] pat;
    wptr = '0;
    a_rstn_i = 1'b1;
    start_i = 1'b0;
    m_tready_i = 1'b1;
    frame_words_i = '0;
    #1 a_rstn_i = 1'b0;
    step();
    step();
    chk("reset_outputs", {fifo_rd_en_o, m_tdata_o, m_tvalid_o, m_tlast_o, busy_o, done_o, resid_drop_o}, 0);
    a_rstn_i = 1'b1;
    step();

    b0 = nb; p0 = npop; d0 = ndone;
    push(48'h1111_2222_3333);
    push(48'h4444_5555_6666);
    start_frame(3);
    wait_done(d0 + 1, "basic_done");
    chk("basic_b1", beat[b0], {1'b0, 32'h2222_3333});
    chk("basic_b2", beat[b0+1], {1'b0, 32'h6666_1111});
    chk("basic_b3", beat[b0+2], {1'b1, 32'h4444_5555});
    chk("basic_nbeats", nb - b0, 3);
    chk("basic_pops", npop - p0, 2);
    chk("basic_done_lat", done_cyc - beat_cyc[b0+2], 1);
    chk("basic_drop", last_drop, 0);
    chk("basic_beat_lat", beat_cyc[b0+2] - beat_cyc[b0], 2);

    b0 = nb; p0 = npop; d0 = ndone; s0 = stall_chk; sb0 = stall_bad;
    pat = 6'b101001;
    push(48'h1111_2222_3333);
    push(48'h4444_5555_6666);
    start_frame(3);
    for (int i = 0; i < 6; i++) begin
      m_tready_i = pat[i];
      step();
    end
    m_tready_i = 1'b1;
    wait_done(d0 + 1, "bp_done");
    chk("bp_b1", beat[b0], {1'b0, 32'h2222_3333});
    chk("bp_b2", beat[b0+1], {1'b0, 32'h6666_1111});
    chk("bp_b3", beat[b0+2], {1'b1, 32'h4444_5555});
    chk("bp_nbeats", nb - b0, 3);
    chk("bp_pops", npop - p0, 2);
    chk("bp_stall_cycles", stall_chk - s0, 3);
    chk("bp_stall_violations", stall_bad - sb0, 0);

    b0 = nb; d0 = ndone;
    push(48'h0102_0304_0506);
    push(48'h0708_090A_0B0C);
    start_frame(6);
    wait_nb(b0 + 3, "ur_first3");
    repeat (5) step();
    chk("ur_tvalid_low", m_tvalid_o, 0);
    chk("ur_busy", busy_o, 1);
    cp = cyc;
    push(48'h0D0E_0F10_1112);
    push(48'h1314_1516_1718);
    wait_done(d0 + 1, "ur_done");
    chk("ur_b1", beat[b0], {1'b0, 32'h0304_0506});
    chk("ur_b2", beat[b0+1], {1'b0, 32'h0B0C_0102});
    chk("ur_b3", beat[b0+2], {1'b0, 32'h0708_090A});
    chk("ur_b4", beat[b0+3], {1'b0, 32'h0F10_1112});
    chk("ur_b5", beat[b0+4], {1'b0, 32'h1718_0D0E});
    chk("ur_b6", beat[b0+5], {1'b1, 32'h1314_1516});
    chk("ur_p2_not_delayed", beat_cyc[b0+2] - beat_cyc[b0+1], 1);
    chk("ur_resume_lat", beat_cyc[b0+3] - cp, 2);
    chk("ur_nbeats", nb - b0, 6);
    chk("ur_drop", last_drop, 0);

    b0 = nb; p0 = npop; d0 = ndone;
    push(48'hAAAA_BBBB_CCCC);
    push(48'hDDDD_EEEE_FFFF);
    start_frame(2);
    wait_done(d0 + 1, "rd_done");
    chk("rd_b1", beat[b0], {1'b0, 32'hBBBB_CCCC});
    chk("rd_b2", beat[b0+1], {1'b1, 32'hFFFF_AAAA});
    chk("rd_nbeats", nb - b0, 2);
    chk("rd_pops", npop - p0, 2);
    chk("rd_drop", last_drop, 1);

    b0 = nb;
    start_frame(0);
    chk("zero_done", done_o, 1);
    chk("zero_busy", busy_o, 0);
    step();
    chk("zero_done_pulse", done_o, 0);
    chk("zero_no_tvalid", {m_tvalid_o, nb - b0}, 0);

    b0 = nb; d0 = ndone;
    push(48'h1234_5678_9ABC);
    push(48'hFEDC_BA98_7654);
    start_frame(3);
    chk("busy_set", busy_o, 1);
    start_frame(5);
    wait_done(d0 + 1, "busy_done");
    chk("busy_b1", beat[b0], {1'b0, 32'h5678_9ABC});
    chk("busy_b2", beat[b0+1], {1'b0, 32'h7654_1234});
    chk("busy_b3", beat[b0+2], {1'b1, 32'hFEDC_BA98});
    chk("busy_drop", last_drop, 0);
    repeat (3) step();
    chk("busy_nbeats", nb - b0, 3);
    chk("busy_idle", {busy_o, m_tvalid_o}, 0);

    b0 = nb; d0 = ndone;
    push(48'h0102_0304_0506);
    push(48'h0708_090A_0B0C);
    push(48'h0D0E_0F10_1112);
    push(48'h1314_1516_1718);
    start_frame(6);
    wait_nb(b0 + 1, "ar_first");
    chk("ar_beat2_valid", {m_tvalid_o, m_tdata_o}, {1'b1, 32'h0B0C_0102});
    #2 a_rstn_i = 1'b0;
    #1;
    chk("ar_outputs_async", {fifo_rd_en_o, m_tdata_o, m_tvalid_o, m_tlast_o, busy_o, done_o, resid_drop_o}, 0);
    step();
    step();
    a_rstn_i = 1'b1;
    step();
    chk("ar_no_done", ndone - d0, 0);
    b0 = nb;
    push(48'h1234_5678_9ABC);
    push(48'hFEDC_BA98_7654);
    start_frame(3);
    wait_done(d0 + 1, "ar_done");
    chk("ar_b1", beat[b0], {1'b0, 32'h5678_9ABC});
    chk("ar_b2", beat[b0+1], {1'b0, 32'h7654_1234});
    chk("ar_b3", beat[b0+2], {1'b1, 32'hFEDC_BA98});
    chk("ar_nbeats", nb - b0, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
